// File: rtl/mem_pkg.sv
// Shared definitions for the parametrised main-memory controller:
// FSM state encoding and legal read-latency bounds.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;

  function automatic bit rd_lat_ok(input int unsigned lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-response pipeline: RD_LAT valid/data stages; each data stage only
// loads when its input is valid, so the last stage holds between responses.
module ram_rd_pipe
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  if (!rd_lat_ok(RD_LAT)) begin : g_lat_chk
    $error("ram_rd_pipe: RD_LAT outside legal range");
  end

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [DATA_W-1:0] dat_q [RD_LAT];
  logic [DATA_W-1:0] dat_d [RD_LAT];

  // Stage 0 captures the array read; later stages shift forward.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = in_valid;
    dat_d[0] = in_valid ? in_data : dat_q[0];
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= dat_d[i];
    end
  end

  assign out_valid = vld_q[RD_LAT-1];
  assign out_data  = dat_q[RD_LAT-1];

endmodule

// File: rtl/ram_ctrl.sv
// Single-port main memory with valid/ready requests, optional post-reset
// zero-fill sweep and a configurable registered read latency.
module ram_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned RD_LAT         = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              rd_fire;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Next state, sweep counter and registered handshake/status outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RST:   state_d = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      ST_CLEAR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == CNT_W'(DEPTH)) state_d = ST_RUN;
      end
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_RST;
    endcase
    req_ready_d = (state_d == ST_RUN);
    busy_d      = (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Single write port shared by the sweep and accepted writes.
  always_comb begin
    accept    = req_valid & req_ready_q;
    rd_fire   = accept & ~req_write;
    mem_we    = 1'b0;
    mem_waddr = req_addr;
    mem_wdata = req_wdata;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q[ADDR_W-1:0];
      mem_wdata = '0;
    end else if (accept && req_write) begin
      mem_we = 1'b1;
    end
  end

  // Array has no reset so contents survive rst_n when the sweep is disabled.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  ram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_fire),
    .in_data   (mem[req_addr]),
    .out_valid (rsp_valid),
    .out_data  (rsp_rdata)
  );

  assign req_ready = req_ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: three configurations driven with shared stimulus and
// each checked against its own word-array / due-cycle scoreboard.
module tb_ram_ctrl;

  localparam int LAT [3] = '{1, 3, 2};
  localparam bit CLR [3] = '{1'b1, 1'b1, 1'b0};
  localparam int NCYC = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write;
  logic [3:0]  req_addr;
  logic [15:0] req_wdata;
  logic        req_ready [3];
  logic        rsp_valid [3];
  logic [15:0] rsp_rdata [3];
  logic        busy [3];

  always #5 clk = ~clk;

  ram_ctrl #(.ADDR_W(4), .DATA_W(16), .RD_LAT(1), .CLEAR_ON_RESET(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]));

  ram_ctrl #(.ADDR_W(4), .DATA_W(16), .RD_LAT(3), .CLEAR_ON_RESET(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]));

  ram_ctrl #(.ADDR_W(4), .DATA_W(16), .RD_LAT(2), .CLEAR_ON_RESET(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[2]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .busy(busy[2]));

  // Reference model: word arrays with known flags, responses keyed by due cycle.
  logic [15:0] mm [3][16];
  bit          kn [3][16];
  bit          ev [3][NCYC];
  logic [15:0] ed [3][NCYC];
  bit          ek [3][NCYC];
  logic [15:0] last_d [3];
  bit          last_k [3];
  bit          rdy_m [3];
  bit          bsy_m [3];
  int          cyc;
  int          n_rel;
  int          nvec;
  int          nerr;
  int          busy_cnt;
  bit          pre_rdy;
  bit          got;

  task automatic chk(input string tag, input int d, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s dut%0d cycle %0d: got %h want %h", tag, d, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    bit acc [3];
    int t;
    for (int d = 0; d < 3; d++) acc[d] = rst_n && req_valid && rdy_m[d];
    @(posedge clk);
    cyc++;
    if (cyc >= NCYC - 8) begin
      nerr++;
      $fatal(1, "FAIL cycle_budget exceeded: got %0d want < %0d", cyc, NCYC - 8);
    end
    if (rst_n) n_rel++;
    for (int d = 0; d < 3; d++) begin
      if (CLR[d] && rst_n && n_rel == 1)
        for (int a = 0; a < 16; a++) begin mm[d][a] = '0; kn[d][a] = 1'b1; end
      if (acc[d]) begin
        if (req_write) begin
          mm[d][req_addr] = req_wdata;
          kn[d][req_addr] = 1'b1;
        end else begin
          t = cyc + LAT[d] - 1;
          ev[d][t] = 1'b1;
          ed[d][t] = mm[d][req_addr];
          ek[d][t] = kn[d][req_addr];
        end
      end
      rdy_m[d] = rst_n && (CLR[d] ? (n_rel >= 17) : (n_rel >= 1));
      bsy_m[d] = rst_n && CLR[d] && (n_rel >= 1) && (n_rel <= 16);
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("req_ready", d, 32'(req_ready[d]), 32'(rdy_m[d]));
      chk("busy", d, 32'(busy[d]), 32'(bsy_m[d]));
      chk("rsp_valid", d, 32'(rsp_valid[d]), 32'(ev[d][cyc]));
      if (ev[d][cyc]) begin
        last_d[d] = ed[d][cyc];
        last_k[d] = ek[d][cyc];
        ev[d][cyc] = 1'b0;
      end
      if (last_k[d]) chk("rsp_rdata", d, 32'(rsp_rdata[d]), 32'(last_d[d]));
    end
  endtask

  task automatic do_reset(input int edges);
    rst_n = 1'b0;
    #1;
    n_rel = 0;
    for (int d = 0; d < 3; d++) begin
      for (int t = cyc; t < cyc + 8; t++) ev[d][t] = 1'b0;
      last_d[d] = '0;
      last_k[d] = 1'b1;
      rdy_m[d]  = 1'b0;
      bsy_m[d]  = 1'b0;
      chk("rst_rsp_valid", d, 32'(rsp_valid[d]), 32'h0);
      chk("rst_rsp_rdata", d, 32'(rsp_rdata[d]), 32'h0);
      chk("rst_req_ready", d, 32'(req_ready[d]), 32'h0);
      chk("rst_busy", d, 32'(busy[d]), 32'h0);
    end
    repeat (edges) tick();
    rst_n = 1'b1;
  endtask

  task automatic op(input bit w, input logic [3:0] a, input logic [15:0] dta);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = dta;
    tick();
  endtask

  task automatic idle(input int k);
    req_valid = 1'b0;
    repeat (k) tick();
  endtask

  initial begin
    nvec = 0; nerr = 0; cyc = 0; n_rel = 0;
    rst_n = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    for (int d = 0; d < 3; d++)
      for (int a = 0; a < 16; a++) kn[d][a] = 1'b0;
    #2;
    do_reset(3);

    // Held read of address 5 across the sweep; sweep length on dut0.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd5;
    busy_cnt = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      pre_rdy = rdy_m[0];
      tick();
      if (busy[0] === 1'b1) busy_cnt++;
      if (pre_rdy) got = 1'b1;
    end
    chk("sweep_len", 0, 32'(busy_cnt), 32'd16);
    idle(5);

    for (int a = 0; a < 16; a++) op(1'b0, 4'(a), 16'h0);
    idle(5);

    op(1'b1, 4'd0, 16'h200a);
    op(1'b0, 4'd0, 16'h0);
    idle(4);

    op(1'b1, 4'd10, 16'h0f0f);
    op(1'b1, 4'd11, 16'hf102);
    op(1'b1, 4'd12, 16'h0000);
    op(1'b0, 4'd10, 16'h0);
    op(1'b0, 4'd11, 16'h0);
    op(1'b0, 4'd12, 16'h0);
    idle(5);

    // Retention across reset on the no-sweep instance.
    op(1'b1, 4'd4, 16'h7020);
    idle(1);
    do_reset(2);
    op(1'b0, 4'd4, 16'h0);
    op(1'b0, 4'd4, 16'h0);
    idle(20);

    // Fill, reset with a read in flight, interrupt the next sweep, re-read.
    for (int a = 0; a < 16; a++) op(1'b1, 4'(a), 16'($urandom_range(1, 16'hffff)));
    op(1'b0, 4'd4, 16'h0);
    do_reset(2);
    idle(6);
    do_reset(1);
    idle(20);
    for (int a = 0; a < 16; a++) op(1'b0, 4'(a), 16'h0);
    idle(5);

    repeat (300) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 4'($urandom_range(0, 15));
      req_wdata = 16'($urandom);
      tick();
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
